// File: rtl/seq_det_ctrl.sv
// rtl/seq_det_ctrl.sv - word-level sequencer for a bit-serial Mealy "1011" detector.
// Optional SEQ_DET_CTRL_KEEP_EN adds keep_state to skip the detector clear between words.
module seq_det_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
`ifdef SEQ_DET_CTRL_KEEP_EN
  input  logic             keep_state,
`endif
  output logic             in_ready,
  output logic             det_rst,
  output logic             det_d_in,
  input  logic             det_d_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] match_pos,
  output logic [CNT_W-1:0] match_total
);

  localparam int K_W = $clog2(WIDTH);
  localparam logic [K_W-1:0]   K_LAST  = K_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SHIFT, S_DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] match_pos_q;
  logic [CNT_W-1:0] total_q;
  logic [K_W-1:0]   k_q;
  logic             skip_clear;
  logic [WIDTH-1:0] hit_mask;

`ifdef SEQ_DET_CTRL_KEEP_EN
  assign skip_clear = keep_state;
`else
  assign skip_clear = 1'b0;
`endif

  // Bit k of the scan lands in match_pos[WIDTH-1-k] because words go out MSB-first.
  assign hit_mask = MSB_ONE >> k_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      match_pos_q <= '0;
      total_q     <= '0;
      k_q         <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            shift_q     <= in_data;
            match_pos_q <= '0;
            k_q         <= '0;
            state_q     <= skip_clear ? S_SHIFT : S_CLEAR;
          end
        end
        S_CLEAR: state_q <= S_SHIFT;
        S_SHIFT: begin
          if (det_d_out) begin
            match_pos_q <= match_pos_q | hit_mask;
            if (total_q != CNT_MAX) total_q <= total_q + 1'b1;
          end
          shift_q <= shift_q << 1;
          k_q     <= k_q + 1'b1;
          if (k_q == K_LAST) state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == S_IDLE) && !rst;
  assign det_rst     = rst || (state_q == S_CLEAR);
  assign det_d_in    = (state_q == S_SHIFT) && shift_q[WIDTH-1];
  assign busy        = (state_q == S_CLEAR) || (state_q == S_SHIFT);
  assign done        = (state_q == S_DONE);
  assign match_pos   = match_pos_q;
  assign match_total = total_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb/tb_seq_det_ctrl.sv - scoreboard bench for seq_det_ctrl with a behavioural 1011 detector.
module tb_seq_det_ctrl;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
`ifdef SEQ_DET_CTRL_KEEP_EN
  logic          keep_state = 1'b0;
`endif
  logic          in_ready, det_rst, det_d_in, det_d_out, busy, done;
  logic [W-1:0]  match_pos;
  logic [CW-1:0] match_total;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  seq_det_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
`ifdef SEQ_DET_CTRL_KEEP_EN
    .keep_state(keep_state),
`endif
    .in_ready(in_ready), .det_rst(det_rst), .det_d_in(det_d_in), .det_d_out(det_d_out),
    .busy(busy), .done(done), .match_pos(match_pos), .match_total(match_total)
  );

  // Detector model: remembers the last three shifted bits; outside shifting it drives noise.
  logic [2:0] hist = 3'b000;
  logic       junk = 1'b0;
  logic       shifting;
  assign shifting  = busy && !det_rst;
  assign det_d_out = shifting ? ((hist == 3'b101) && det_d_in) : junk;
  always @(posedge clk) begin
    if (det_rst) hist <= 3'b000;
    else if (shifting) hist <= {hist[1:0], det_d_in};
  end
  always @(negedge clk) junk <= 1'($urandom_range(0, 1));

  logic [W-1:0] seen = '0;
  int           seen_n = 0;
  always @(posedge clk) begin
    if (rst || done) begin
      seen   <= '0;
      seen_n <= 0;
    end else if (shifting) begin
      seen   <= {seen[W-2:0], det_d_in};
      seen_n <= seen_n + 1;
    end
  end

  typedef struct {
    logic [W-1:0]  word;
    logic [W-1:0]  pos;
    logic [CW-1:0] tot;
    int            lat;
    int            acc;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [2:0] tail = 3'b000;
  int         m_total = 0;

  function automatic logic [W-1:0] ref_pos(input logic [2:0] t, input logic [W-1:0] w);
    logic [W+2:0] s;
    logic [W-1:0] r;
    s = {t, w};
    r = '0;
    for (int k = 0; k < W; k++)
      if (s[W-1-k +: 4] == 4'b1011) r[W-1-k] = 1'b1;
    return r;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("match_pos", 32'(match_pos), 32'(e.pos));
          chk("match_total", 32'(match_total), 32'(e.tot));
          chk("done_latency", 32'(cyc - e.acc), 32'(e.lat));
          chk("shifted_bits", 32'(seen), 32'(e.word));
          chk("shifted_count", 32'(seen_n), 32'(W));
          chk("ready_busy_in_done", {30'd0, in_ready, busy}, 32'd0);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_det_rst"}, 32'(det_rst), 32'd1);
    chk({tag, "_det_d_in"}, 32'(det_d_in), 32'd0);
    chk({tag, "_busy_done"}, {30'd0, busy, done}, 32'd0);
    chk({tag, "_match_pos"}, 32'(match_pos), 32'd0);
    chk({tag, "_match_total"}, 32'(match_total), 32'd0);
  endtask

  // abort > 0: assert rst at that negedge after the accept (1 = first cycle after accept).
  task automatic send(input logic [W-1:0] d, input bit keep, input int abort);
    int   t;
    bit   eff;
    exp_t e;
    logic [W-1:0] p;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      return;
    end
    in_valid = 1'b1;
    in_data  = d;
`ifdef SEQ_DET_CTRL_KEEP_EN
    keep_state = keep;
    eff = keep;
`else
    eff = 1'b0;
    if (keep) eff = 1'b0;
`endif
    @(posedge clk);
    #1;
    if (!eff) tail = 3'b000;
    p = ref_pos(tail, d);
    tail = d[2:0];
    m_total = m_total + $countones(p);
    if (m_total > (1 << CW) - 1) m_total = (1 << CW) - 1;
    e.word = d;
    e.pos  = p;
    e.tot  = CW'(m_total);
    e.lat  = eff ? W : W + 1;
    e.acc  = cyc;
    sb.push_back(e);
    // Hold in_valid with junk data while the word is in flight; it must be ignored.
    t = 0;
    while (t < W + 10) begin
      @(negedge clk);
      t++;
      in_data = W'($urandom);
      if (done) break;
      if (abort > 0 && t == abort) begin
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        tail = 3'b000;
        m_total = 0;
        check_reset_outputs("midword_rst");
        @(negedge clk);
        rst = 1'b0;
        return;
      end
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin : stim
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_det_rst", 32'(det_rst), 32'd0);
    repeat (3) @(negedge clk);
    chk("idle_outputs", {22'd0, busy, done, match_pos}, 32'd0);
    chk("idle_total", 32'(match_total), 32'd0);

    send(8'b1011_0110, 1'b0, 0);
    chk("overlap_pos", 32'(match_pos), 32'b0001_0010);
    chk("overlap_total", 32'(match_total), 32'd2);
    send(8'b0000_0000, 1'b0, 0);
    chk("zeros_pos", 32'(match_pos), 32'd0);
    send(8'b1111_1111, 1'b0, 0);
    chk("ones_pos", 32'(match_pos), 32'd0);
    chk("no_match_total", 32'(match_total), 32'd2);

    send(8'b1011_1011, 1'b0, 5);
    send(8'b1011_0000, 1'b0, 0);
    chk("after_rst_pos", 32'(match_pos), 32'b0001_0000);
    chk("after_rst_total", 32'(match_total), 32'd1);

`ifdef SEQ_DET_CTRL_KEEP_EN
    send(8'b0000_0101, 1'b0, 0);
    send(8'b1000_0000, 1'b1, 0);
    chk("keep_cross_pos", 32'(match_pos), 32'b1000_0000);
    send(8'b0000_0101, 1'b0, 0);
    send(8'b1000_0000, 1'b0, 0);
    chk("nokeep_cross_pos", 32'(match_pos), 32'd0);
`endif

    for (int i = 0; i < 150; i++) begin
      send(W'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, W)) : 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (W + 5) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
